// File: rtl/ahfp_f2f_arbiter.sv
// Round-robin arbiter sharing one fixed-to-float converter among NREQ requesters.
// Tracks each conversion's owner and returns results through per-lane result registers.
module ahfp_f2f_arbiter #(
    parameter int NREQ     = 4,
    parameter int CONV_LAT = 1,
    parameter int W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   res_valid,
    output logic [NREQ*W-1:0] res_data,
    input  logic [NREQ-1:0]   res_ready,
    output logic [W-1:0]      conv_in,
    input  logic [W-1:0]      conv_out,
    output logic              busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                          run_r;
    logic [IDW-1:0]                ptr_r;
    logic [IDW-1:0]                ptr_nxt_s;
    logic [CONV_LAT-1:0]           tag_v_r;
    logic [CONV_LAT-1:0]           tag_zero_r;
    logic [CONV_LAT-1:0][IDW-1:0]  tag_id_r;
    logic [CONV_LAT:0]             tag_v_in_s;
    logic [CONV_LAT:0]             tag_zero_in_s;
    logic [CONV_LAT:0][IDW-1:0]    tag_id_in_s;
    logic [NREQ-1:0]               res_valid_r;
    logic [NREQ*W-1:0]             res_data_r;
    logic [NREQ-1:0]               inflight_s;
    logic [NREQ-1:0]               eligible_s;
    logic [NREQ-1:0]               grant_s;
    logic                          grant_any_s;
    logic [IDW-1:0]                grant_id_s;
    logic [W-1:0]                  grant_data_s;
    logic                          grant_zero_s;
    logic                          cap_v_s;
    logic [IDW-1:0]                cap_id_s;
    logic [W-1:0]                  cap_data_s;

    // Lanes owning an in-flight conversion; only registered state feeds eligibility.
    always_comb begin
        inflight_s = {NREQ{1'b0}};
        for (int s = 0; s < CONV_LAT; s++) begin
            inflight_s[tag_id_r[s]] = inflight_s[tag_id_r[s]] | tag_v_r[s];
        end
        eligible_s = req_valid & ~res_valid_r & ~inflight_s & {NREQ{run_r}};
    end

    // Round-robin search from ptr, wrapping modulo NREQ; first eligible lane wins.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        grant_any_s = 1'b0;
        grant_id_s  = {IDW{1'b0}};
        grant_s     = {NREQ{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(ptr_r) + k) % NREQ;
            if (!grant_any_s && eligible_s[idx_v]) begin
                grant_any_s = 1'b1;
                grant_id_s  = idx_v[IDW-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        grant_s[grant_id_s] = grant_any_s;
    end

    // Granted lane's data to the converter, plus next pointer and zero detect.
    always_comb begin
        grant_data_s = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_data_s = grant_data_s | (req_data[i*W +: W] & {W{grant_s[i]}});
        end
        grant_zero_s = (grant_data_s == {W{1'b0}});
        if (!grant_any_s) begin
            ptr_nxt_s = ptr_r;
        end else if (grant_id_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = {IDW{1'b0}};
        end else begin
            ptr_nxt_s = grant_id_s + IDW'(1);
        end
    end

    // Tag shift inputs: new entry at the bottom, oldest entry falls out the top.
    always_comb begin
        tag_v_in_s    = {tag_v_r, grant_any_s};
        tag_zero_in_s = {tag_zero_r, grant_zero_s};
        tag_id_in_s   = {tag_id_r, grant_id_s};
        cap_v_s       = tag_v_r[CONV_LAT-1];
        cap_id_s      = tag_id_r[CONV_LAT-1];
        cap_data_s    = tag_zero_r[CONV_LAT-1] ? {W{1'b0}} : conv_out;
    end

    // Pointer, run enable and tag pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r      <= 1'b0;
            ptr_r      <= {IDW{1'b0}};
            tag_v_r    <= {CONV_LAT{1'b0}};
            tag_zero_r <= {CONV_LAT{1'b0}};
            tag_id_r   <= {(CONV_LAT*IDW){1'b0}};
        end else begin
            run_r      <= 1'b1;
            ptr_r      <= ptr_nxt_s;
            tag_v_r    <= tag_v_in_s[CONV_LAT-1:0];
            tag_zero_r <= tag_zero_in_s[CONV_LAT-1:0];
            tag_id_r   <= tag_id_in_s[CONV_LAT-1:0];
        end
    end

    // Per-lane result registers: capture from the last tag stage, clear on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= {NREQ{1'b0}};
            res_data_r  <= {(NREQ*W){1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cap_v_s && (cap_id_s == IDW'(i))) begin
                    res_valid_r[i]      <= 1'b1;
                    res_data_r[i*W +: W] <= cap_data_s;
                end else if (res_valid_r[i] && res_ready[i]) begin
                    res_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready = grant_s;
    assign conv_in   = grant_data_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign busy      = (|tag_v_r) | (|res_valid_r);

endmodule
